// File: rtl/gpio_in_debounce.sv
// Synchronises and debounces WIDTH asynchronous pins, giving a 32-bit level word,
// per-bit edge pulses and, with `GPIO_IN_IRQ_EN defined, a latched masked interrupt.
module gpio_in_debounce #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 480000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [31:0]      gpio_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic             r_s1;
            logic             r_s2;
            logic             r_stable;
            logic             r_rise;
            logic             r_fall;
            logic [CNT_W-1:0] r_cnt;

            // Any sample agreeing with the accepted level restarts the count,
            // so only DB_CYCLES consecutive disagreeing samples are accepted.
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_stable <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1   <= pin_i[gi];
                    r_s2   <= r_s1;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (r_s2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                        r_rise   <= r_s2;
                        r_fall   <= ~r_s2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_stable[gi] = r_stable;
            assign w_rise[gi]   = r_rise;
            assign w_fall[gi]   = r_fall;
        end
    endgenerate

    assign gpio_i = 32'(w_stable);
    assign rise_o = w_rise;
    assign fall_o = w_fall;

`ifdef GPIO_IN_IRQ_EN
    logic [WIDTH-1:0] r_pend;
    logic             r_irq;

    // A new rise outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_rise | (r_pend & ~irq_clr);
            r_irq  <= |(r_pend & irq_en);
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_en, irq_clr};
    assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce (WIDTH=8, DB_CYCLES=4); the reference model accepts a
// level once the last DB_CYCLES synchronised samples all disagree with the current one.
module tb_gpio_in_debounce;

    localparam int W  = 8;
    localparam int DB = 4;
`ifdef GPIO_IN_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  pin;
    logic [31:0]   gpio_i;
    logic [W-1:0]  rise_o;
    logic [W-1:0]  fall_o;
    logic [W-1:0]  irq_en;
    logic [W-1:0]  irq_clr;
    logic          irq_o;

    int total = 0;
    int bad   = 0;

    gpio_in_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pin_i         (pin),
        .gpio_i        (gpio_i),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .irq_en        (irq_en),
        .irq_clr       (irq_clr),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: history of pin samples, newest first.
    logic [W-1:0] hq[$];
    logic [W-1:0] m_stable, m_rise, m_fall, m_pend;
    logic         m_irq;

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < DB + 2; i++) hq.push_back('0);
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_pend   = '0;
        m_irq    = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] acc;
        logic [W-1:0] pend_n;
        logic         irq_n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hq.push_front(pin);
        // A pin sampled at edge n reaches the comparison at edge n+2.
        acc = '1;
        for (int j = 2; j < DB + 2; j++) acc &= hq[j] ^ m_stable;
        void'(hq.pop_back());
        irq_n    = |(m_pend & irq_en);
        pend_n   = m_rise | (m_pend & ~irq_clr);
        m_rise   = acc & ~m_stable;
        m_fall   = acc & m_stable;
        m_stable = m_stable ^ acc;
        m_pend   = IRQ ? pend_n : '0;
        m_irq    = IRQ ? irq_n : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [48:0] exp_vec();
        return {24'h0, m_stable, m_rise, m_fall, m_irq};
    endfunction

    function automatic logic [48:0] act_vec();
        return {gpio_i, rise_o, fall_o, irq_o};
    endfunction

    task automatic test_reset();
        int rises = 0;
        rst_n = 1'b0; pin = 8'hFF; irq_en = 8'h01; irq_clr = '0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (act_vec() !== 49'h0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", k, act_vec());
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (rise_o == 8'hFF) rises++;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_release k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
            total++;
            if (gpio_i !== ((k >= DB + 2) ? 32'hFF : 32'h0)) begin
                bad++;
                $display("FAIL reset_latency k=%0d gpio=%h", k, gpio_i);
            end
        end
        total++;
        if (rises !== 1) begin
            bad++;
            $display("FAIL reset_rise_count got=%0d want=1", rises);
        end
    endtask

    task automatic settle(input logic [W-1:0] p, input int n);
        pin = p;
        for (int k = 0; k < n; k++) begin
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL settle got=%h want=%h", act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_press();
        irq_en = '0;
        pin = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL press_model k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
            total++;
            if (gpio_i[0] !== (k >= DB + 2) || rise_o[0] !== (k == DB + 2)) begin
                bad++;
                $display("FAIL press_edge k=%0d gpio0=%b rise0=%b", k, gpio_i[0], rise_o[0]);
            end
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                pin = (k < 3) ? 8'h03 : 8'h01;
                step();
                total++;
                if (gpio_i !== 32'h1 || rise_o !== 8'h0 || fall_o !== 8'h0
                    || act_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL glitch r=%0d k=%0d got=%h want gpio=1 no pulses", r, k, act_vec());
                end
            end
        end
        settle(8'h01, 6);
    endtask

    task automatic test_release();
        irq_clr = 8'hFF; irq_en = 8'h01;
        step();
        irq_clr = '0;
        step();
        pin = 8'h00;
        for (int k = 1; k <= 9; k++) begin
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL release_model k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
            total++;
            if (fall_o[0] !== (k == DB + 2) || gpio_i[0] !== (k < DB + 2) || irq_o !== 1'b0) begin
                bad++;
                $display("FAIL release_edge k=%0d fall0=%b gpio0=%b irq=%b", k, fall_o[0], gpio_i[0], irq_o);
            end
        end
    endtask

    task automatic test_irq();
        irq_en = 8'h01; irq_clr = '0;
        pin = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if (irq_o !== (IRQ && k >= DB + 4) || act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL irq_set k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
        end
        irq_clr = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            step();
            irq_clr = '0;
            total++;
            if (irq_o !== (IRQ && k == 1) || act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL irq_clear k=%0d irq=%b want=%b", k, irq_o, IRQ && k == 1);
            end
        end
        settle(8'h00, 10);
        irq_clr = 8'h01;
        settle(8'h01, DB + 3);
        irq_clr = '0;
        settle(8'h01, 3);
        total++;
        if (irq_o !== IRQ) begin
            bad++;
            $display("FAIL irq_set_wins irq=%b want=%b", irq_o, IRQ);
        end
        irq_clr = 8'h01;
        step();
        irq_clr = '0;
        settle(8'h01, 3);
        pin = 8'h05;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (irq_o !== 1'b0 || act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL irq_masked k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] p = pin;
        int cyc = 0;
        while (cyc < 1500) begin
            int hold = $urandom_range(1, 7);
            p ^= W'($urandom) & W'($urandom);
            irq_en = W'($urandom);
            for (int k = 0; k < hold; k++) begin
                pin = p;
                irq_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
                step();
                cyc++;
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
                end
            end
        end
        irq_clr = '0;
    endtask

    task automatic test_reset_mid();
        settle(8'h00, 12);
        irq_clr = 8'hFF;
        step();
        irq_clr = '0;
        pin = 8'h08;
        for (int k = 0; k < 4; k++) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (act_vec() !== 49'h0) begin
            bad++;
            $display("FAIL reset_mid_async got=%h want=0", act_vec());
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (act_vec() !== exp_vec() || gpio_i !== ((k >= DB + 2) ? 32'h8 : 32'h0)) begin
                bad++;
                $display("FAIL reset_mid_recover k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        settle(8'h00, 10);
        test_press();
        test_glitch();
        test_release();
        test_irq();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-direction companion to the SoC GPIO output path: samples asynchronous board inputs (user button, header pins), synchronises and debounces them, and presents a clean 32-bit word on the SoC's `uart_gpio_i` port. It replaces the constant-zero tie-off with real inputs. It also produces per-bit edge pulses and an optional latched interrupt.

## Interface
Parameters:
- `WIDTH`, 8: number of physical input pins; 1..32.
- `DB_CYCLES`, 480000: consecutive stable clocks required to accept a new level (10 ms at 48 MHz); must be ≥1.

Ports:
- `clk_clk` in 1: the single clock, 48 MHz system clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `pin_i` in WIDTH: raw asynchronous pin levels, active-high.
- `gpio_i` out 32: debounced levels, `{(32-WIDTH)'b0, stable}`; connects to the SoC's `uart_gpio_i`.
- `rise_o` out WIDTH: one-cycle pulse per bit on accepted 0→1.
- `fall_o` out WIDTH: one-cycle pulse per bit on accepted 1→0.
- `irq_en` in WIDTH: per-bit interrupt mask.
- `irq_clr` in WIDTH: per-bit pending clear, sampled each cycle while high.
- `irq_o` out 1: `|(pend & irq_en)`, registered.

## Operation
- Per bit: 2-flop synchroniser `s1→s2`. Debounce counter `cnt` is `$clog2(DB_CYCLES+1)` bits wide. Register `stable` holds the accepted level.
- Each clock, per bit:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `stable <= s2`, `cnt <= 0`, and pulse `rise_o` or `fall_o` per the new level.
  - Else: `cnt <= cnt+1`.
- Any single cycle with `s2 == stable` restarts the count. Glitches shorter than `DB_CYCLES` cycles are discarded entirely.
- `cnt` never exceeds `DB_CYCLES-1`. No wrap-around is possible.
- Bits are fully independent. Simultaneous changes on several bits give simultaneous pulses.
- Pending register `pend[i]`:
  - Set on `rise_o[i]`.
  - Cleared when `irq_clr[i]`=1.
  - Set and clear in the same cycle: set wins, `pend[i]` stays 1.
- `irq_en` masks `irq_o` only; `pend` still latches while masked.
- Reset (asynchronous assert, any time including mid-count):
  - `s1`, `s2`, `cnt`, `stable`, `pend` = 0.
  - All outputs = 0.
  - An in-progress debounce is abandoned.
  - After release, a pin held high is accepted through a normal `DB_CYCLES` count and produces a `rise_o` pulse.

## Timing
- Pin level change first captured by `s1` at clock edge E.
- `s2` reflects it at E+1.
- `stable`, `gpio_i` and the edge pulse update at E+1+`DB_CYCLES`; total latency `DB_CYCLES+1` edges after E.
- `DB_CYCLES`=1: accepted one cycle after `s2` changes.
- `rise_o`/`fall_o` are registered, high for exactly one cycle, coincident with the `gpio_i` change.
- `pend` sets one cycle after the `rise_o` pulse; `irq_o` asserts one cycle after `pend`.
- `irq_clr` takes effect on the next edge; `irq_o` drops one cycle after `pend` clears.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `GPIO_IN_IRQ_EN`.
- Defined: `pend` register and `irq_o` logic are present as described.
- Undefined: no `pend` flops; `irq_o` tied to 0; `irq_en`/`irq_clr` ignored. Debounce, `gpio_i` and edge pulses are unchanged.

## Test plan
1. Reset: hold `reset_reset_n`=0 with `pin_i`=8'hFF → `gpio_i`=0, `rise_o`=`fall_o`=0, `irq_o`=0. Release and hold pins → `gpio_i`=32'h000000FF after `DB_CYCLES+1` edges, with one `rise_o`=8'hFF pulse.
2. Clean press (`DB_CYCLES`=4): `pin_i[0]` 0→1 captured at edge E → `gpio_i[0]`=1 and `rise_o[0]`=1 for one cycle at E+5, not earlier.
3. Glitch (`DB_CYCLES`=4): `pin_i[1]` high for 3 cycles then low; repeat 3 times → `gpio_i` unchanged and no pulses.
4. Release: after test 2, `pin_i[0]`→0 → `fall_o[0]` one-cycle pulse at E+5, `gpio_i[0]`=0, `pend[0]` not set.
5. IRQ (`GPIO_IN_IRQ_EN` defined, `irq_en`=8'h01):
   - Rise on bit 0 → `irq_o`=1 two cycles after `rise_o`.
   - `irq_clr[0]` for one cycle → `irq_o`=0 after two cycles.
   - Rise coincident with `irq_clr[0]` → `pend[0]` stays 1.
   - Rise on bit 2 with `irq_en[2]`=0 → `irq_o` stays 0.
6. Reset mid-count: assert reset at `cnt`=2 → all state 0 immediately. Without the macro, `irq_o`=0 throughout test 5.
